conv1x1_frame_sequencer: RTL

Controller that sequences one frame of IMG_Width×IMG_Height pixels through the 1×1 convolution datapath once per output channel. It gates the upstream pixel stream into the conv stage, holds the conv stage in clear while idle, and tracks the row, column and channel of each issued pixel. It counts the conv stage's returned results and signals frame completion, so it sits between the line/feature buffer and the 1×1 conv stage in the tiny-model pipeline.

---
 rtl/conv1x1_frame_sequencer_if.sv | 29 ++
 rtl/conv1x1_frame_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/conv1x1_frame_sequencer_if.sv
// Pixel stream and conv-stage signals between the frame sequencer and its neighbours.
// The master modport is the sequencer; the slave modport is the upstream/conv side.
//
// Handshake: a pixel moves from upstream into the conv stage in exactly the
// cycles where Src_Valid and Src_Ready are both high at the rising edge of CLK.
// Src_Ready never depends on Src_Valid. Conv_Valid_IN marks that same cycle
// toward the conv stage, and Conv_Valid_OUT is the conv stage's result strobe.
interface conv1x1_frame_sequencer_if #(
    parameter int Datawidth = 16
);
    logic [Datawidth-1:0] Src_Data;
    logic                 Src_Valid;
    logic                 Src_Ready;
    logic                 Dst_Ready;
    logic [Datawidth-1:0] Conv_In;
    logic                 Conv_Valid_IN;
    logic                 Conv_Valid_OUT;
    logic                 Conv_CLR;

    modport master (
        input  Src_Data, Src_Valid, Dst_Ready, Conv_Valid_OUT,
        output Src_Ready, Conv_In, Conv_Valid_IN, Conv_CLR
    );

    modport slave (
        output Src_Data, Src_Valid, Dst_Ready, Conv_Valid_OUT,
        input  Src_Ready, Conv_In, Conv_Valid_IN, Conv_CLR
    );
endinterface

// File: rtl/conv1x1_frame_sequencer.sv
// Sequences one IMG_Width x IMG_Height frame through the 1x1 conv stage once per
// output channel, tracks the position of each offered pixel, counts returned
// results and pulses Done when the last result of the frame has come back.
module conv1x1_frame_sequencer #(
    parameter int IMG_Width  = 3,
    parameter int IMG_Height = 3,
    parameter int CH         = 1,
    parameter int Datawidth  = 16
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      Start,
    conv1x1_frame_sequencer_if.master bus,
    output logic [Datawidth-1:0]      Hang,
    output logic [Datawidth-1:0]      Cot,
    output logic [Datawidth-1:0]      Ch_Idx,
    output logic                      Frame_Last,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Err,
    output logic [2:0]                state_dbg,
    output logic [Datawidth-1:0]      issue_count,
    output logic [Datawidth-1:0]      result_count
);
    localparam logic [Datawidth-1:0] TOTAL    = Datawidth'(IMG_Width * IMG_Height * CH);
    localparam logic [Datawidth-1:0] TOTAL_M1 = Datawidth'(IMG_Width * IMG_Height * CH - 1);
    localparam logic [Datawidth-1:0] W_LAST   = Datawidth'(IMG_Width - 1);
    localparam logic [Datawidth-1:0] H_LAST   = Datawidth'(IMG_Height - 1);
    localparam logic [Datawidth-1:0] C_LAST   = Datawidth'(CH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic in_run;
    logic active;
    logic xfer;
    logic start_ok;
    logic at_last;
    logic res_inc;
    logic res_full_next;

    assign in_run   = (state == S_RUN);
    assign active   = (state == S_ARM) || (state == S_RUN) || (state == S_DRAIN);
    assign xfer     = in_run && bus.Src_Valid && bus.Dst_Ready;
    assign start_ok = (state == S_IDLE) && Start;
    assign at_last  = (Cot == W_LAST) && (Hang == H_LAST) && (Ch_Idx == C_LAST);
    assign res_inc  = bus.Conv_Valid_OUT && active && (result_count < TOTAL);
    // The drain exit counts a result strobe arriving in the same cycle.
    assign res_full_next = (result_count == TOTAL) || (res_inc && (result_count == TOTAL_M1));

    assign bus.Src_Ready     = in_run && bus.Dst_Ready;
    assign bus.Conv_Valid_IN = xfer;
    assign bus.Conv_In       = bus.Src_Data;
    assign bus.Conv_CLR      = (state == S_IDLE);
    assign Frame_Last        = in_run && at_last;
    assign Busy              = active;
    assign Done              = (state == S_DONE);
    assign state_dbg         = state;

    // State register.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (Start) state_next = S_ARM;
            S_ARM:   state_next = S_RUN;
            S_RUN:   if (xfer && at_last) state_next = S_DRAIN;
            S_DRAIN: if (res_full_next) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Row/column/channel of the pixel on offer; advances on each transfer.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Cot    <= '0;
            Hang   <= '0;
            Ch_Idx <= '0;
        end else if (start_ok || (state_next == S_DONE)) begin
            Cot    <= '0;
            Hang   <= '0;
            Ch_Idx <= '0;
        end else if (xfer) begin
            if (Cot == W_LAST) begin
                Cot <= '0;
                if (Hang == H_LAST) begin
                    Hang   <= '0;
                    Ch_Idx <= Ch_Idx + 1'b1;
                end else begin
                    Hang <= Hang + 1'b1;
                end
            end else begin
                Cot <= Cot + 1'b1;
            end
        end
    end

    // Issue and result counters, both saturating at TOTAL.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            issue_count  <= '0;
            result_count <= '0;
        end else if (start_ok) begin
            issue_count  <= '0;
            result_count <= '0;
        end else begin
            if (xfer && (issue_count < TOTAL)) issue_count <= issue_count + 1'b1;
            if (res_inc) result_count <= result_count + 1'b1;
        end
    end

    // Sticky flag for result strobes that no issued pixel accounts for.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Err <= 1'b0;
        end else if (start_ok) begin
            Err <= 1'b0;
        end else if (bus.Conv_Valid_OUT &&
                     ((state == S_IDLE) || (state == S_DONE) || (result_count == TOTAL))) begin
            Err <= 1'b1;
        end
    end
endmodule
